// File: rtl/dcache_wb_if.sv
// Core-side and memory-side signals of the write-back data cache, bundled for port use.
// The master modport is the environment (core plus memory); the slave modport is the cache.
interface dcache_wb_if;
  // Handshakes: the core raises proc_read/proc_write and holds all request
  // fields while proc_stall=1. A request completes on the first rising edge
  // with proc_stall=0. The cache holds mem_read/mem_write with a stable
  // mem_addr/mem_wdata until mem_ready pulses for one cycle, which completes
  // that transfer. mem_ready is ignored when no transfer is pending.
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [1:0]   dbg_state;

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
  );

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata, dbg_state
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 words x 32 bits.
// Misses evict a dirty victim (WRITEBACK) before refilling the line (ALLOCATE).
module dcache_wb (
  input  logic        i_clk,
  input  logic        rst_n,
  dcache_wb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       valid_q, valid_d;
  logic [7:0]       dirty_q, dirty_d;
  logic [24:0]      tag_q  [8];
  logic [24:0]      tag_d  [8];
  logic [3:0][31:0] data_q [8];
  logic [3:0][31:0] data_d [8];

  logic [2:0]  index;
  logic [1:0]  offset;
  logic [24:0] tag;
  logic        req;
  logic        hit;

  assign offset = bus.proc_addr[1:0];
  assign index  = bus.proc_addr[4:2];
  assign tag    = bus.proc_addr[29:5];
  assign req    = bus.proc_read | bus.proc_write;
  assign hit    = valid_q[index] && (tag_q[index] == tag);

  // Read data and victim data are always the addressed line; the core holds
  // the address during a miss, so both stay stable through the transfers.
  assign bus.proc_rdata = data_q[index][offset];
  assign bus.mem_wdata  = data_q[index];
  assign bus.dbg_state  = state_q;

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    dirty_d        = dirty_q;
    tag_d          = tag_q;
    data_d         = data_q;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = {tag, index};

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (bus.proc_write) begin
              data_d[index][offset] = bus.proc_wdata;
              dirty_d[index]        = 1'b1;
            end
          end else begin
            bus.proc_stall = 1'b1;
            state_d = (valid_q[index] && dirty_q[index]) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        bus.proc_stall = 1'b1;
        bus.mem_write  = 1'b1;
        bus.mem_addr   = {tag_q[index], index};
        if (bus.mem_ready) begin
          dirty_d[index] = 1'b0;
          state_d        = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        bus.proc_stall = 1'b1;
        bus.mem_read   = 1'b1;
        if (bus.mem_ready) begin
          data_d[index]  = bus.mem_rdata;
          tag_d[index]   = tag;
          valid_d[index] = 1'b1;
          dirty_d[index] = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tags and data are qualified by valid, so they carry no reset.
  always_ff @(posedge i_clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Bench for dcache_wb: a flat golden memory image predicts load data and victim
// contents; a valid/dirty/tag map of the cache predicts hits, evictions and stalls.
module tb_dcache_wb;

  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  dcache_wb_if bus();

  dcache_wb dut (
    .i_clk (i_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  bit          rv  [8];
  bit          rdy [8];
  logic [24:0] rt  [8];
  logic [31:0]  golden  [logic [29:0]];
  logic [127:0] mem_img [logic [27:0]];
  logic [31:0]  exp_q [$];

  function automatic logic [31:0] init_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] exp_word(input logic [29:0] a);
    if (golden.exists(a)) return golden[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] golden_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = exp_word({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem_img.exists(la)) return mem_img[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, 2'(w)});
    return l;
  endfunction

  // Cache contents vanish on reset: only what memory holds survives.
  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      rv[i]  = 1'b0;
      rdy[i] = 1'b0;
    end
    golden.delete();
    foreach (mem_img[k])
      for (int w = 0; w < 4; w++) golden[{k, 2'(w)}] = mem_img[k][w*32 +: 32];
  endfunction

  task automatic set_idle();
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [29:0] addr,
                           input logic [31:0] wdata, input int lat, input string name);
    logic [2:0]  idx;
    logic [24:0] tg;
    logic [27:0] victim;
    bit          exp_hit, exp_wb, done;
    int          exp_stall, stalls, wb_cnt, rd_cnt, wait_cnt;
    logic [31:0] e;
    idx       = addr[4:2];
    tg        = addr[29:5];
    victim    = {rt[idx], idx};
    exp_hit   = rv[idx] && (rt[idx] == tg);
    exp_wb    = !exp_hit && rv[idx] && rdy[idx];
    exp_stall = exp_hit ? 0 : 1 + (exp_wb ? 2 : 1) * (lat + 1);
    if (rd) exp_q.push_back(exp_word(addr));
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wdata;
    stalls = 0; wb_cnt = 0; rd_cnt = 0; wait_cnt = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      n_cmp++;
      if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
        n_err++;
        $display("FAIL %s both_mem: mem_read and mem_write both 1", name);
      end
      if (bus.proc_stall === 1'b0) begin
        done = 1'b1;
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
          n_err++;
          $display("FAIL %s release_traffic: rd=%b wr=%b required 0 0", name, bus.mem_read, bus.mem_write);
        end
      end else begin
        stalls++;
        if (bus.mem_write === 1'b1) begin
          n_cmp++;
          if (bus.mem_addr !== victim || bus.mem_wdata !== golden_line(victim)) begin
            n_err++;
            $display("FAIL %s wb_line: addr=%h data=%h required addr=%h data=%h",
                     name, bus.mem_addr, bus.mem_wdata, victim, golden_line(victim));
          end
          wait_cnt++;
          if (wait_cnt > lat) begin
            bus.mem_ready = 1'b1;
            mem_img[bus.mem_addr] = bus.mem_wdata;
            wb_cnt++;
            wait_cnt = 0;
          end
        end else if (bus.mem_read === 1'b1) begin
          n_cmp++;
          if (bus.mem_addr !== {tg, idx}) begin
            n_err++;
            $display("FAIL %s fill_addr: got %h required %h", name, bus.mem_addr, {tg, idx});
          end
          bus.mem_rdata = mem_line({tg, idx});
          wait_cnt++;
          if (wait_cnt > lat) begin
            bus.mem_ready = 1'b1;
            rd_cnt++;
            wait_cnt = 0;
          end
        end
        @(posedge i_clk);
        #1;
        bus.mem_ready = 1'b0;
      end
    end
    n_cmp++;
    if (!done || stalls != exp_stall || wb_cnt != int'(exp_wb) || rd_cnt != (exp_hit ? 0 : 1)) begin
      n_err++;
      $display("FAIL %s timing: done=%0d stalls=%0d wb=%0d fill=%0d required done=1 stalls=%0d wb=%0d fill=%0d",
               name, done, stalls, wb_cnt, rd_cnt, exp_stall, exp_wb, exp_hit ? 0 : 1);
    end
    if (rd) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.proc_rdata !== e) begin
        n_err++;
        $display("FAIL %s rdata: addr=%h got %h required %h", name, addr, bus.proc_rdata, e);
      end
    end
    if (!exp_hit) begin
      rv[idx]  = 1'b1;
      rt[idx]  = tg;
      rdy[idx] = 1'b0;
    end
    if (wr) begin
      golden[addr] = wdata;
      rdy[idx]     = 1'b1;
    end
    @(posedge i_clk);
    #1;
    set_idle();
  endtask

  task automatic idle_cycles(input int n, input bit pulse_ready, input string name);
    set_idle();
    for (int i = 0; i < n; i++) begin
      #1;
      n_cmp++;
      if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
        n_err++;
        $display("FAIL %s idle: stall=%b rd=%b wr=%b required 0 0 0",
                 name, bus.proc_stall, bus.mem_read, bus.mem_write);
      end
      if (pulse_ready && i == 1) bus.mem_ready = 1'b1;
      @(posedge i_clk);
      #1;
      bus.mem_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = '0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if (bus.proc_stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: stall=%b rd=%b wr=%b required 0 0 0",
               bus.proc_stall, bus.mem_read, bus.mem_write);
    end
    rst_n = 1'b1;
    idle_cycles(2, 1'b0, "post_reset");
  endtask

  task automatic test_directed();
    logic [127:0] l;
    l = mem_line(28'h1);
    l[63:32] = 32'hDEADBEEF;
    mem_img[28'h1] = l;
    golden[30'h5]  = 32'hDEADBEEF;
    do_access(1, 0, 30'h05, 32'h0, 0, "cold_read");
    do_access(1, 0, 30'h04, 32'h0, 0, "hit_word0");
    do_access(0, 1, 30'h05, 32'h1234_5678, 0, "store_hit");
    do_access(1, 0, 30'h25, 32'h0, 0, "dirty_evict");
    n_cmp++;
    if (mem_img[28'h1][63:32] !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL evicted_word1: got %h required 12345678", mem_img[28'h1][63:32]);
    end
    do_access(0, 1, 30'h45, 32'hCAFE_F00D, 1, "store_miss_clean");
    do_access(1, 0, 30'h45, 32'h0, 0, "store_miss_readback");
    do_access(1, 0, 30'h65, 32'h0, 2, "evict_merged");
    do_access(1, 1, 30'h66, 32'hA5A5_0001, 0, "rd_wr_hit");
    do_access(1, 0, 30'h66, 32'h0, 0, "rd_wr_readback");
  endtask

  task automatic test_idle();
    idle_cycles(5, 1'b1, "idle_ready_pulse");
    do_access(1, 0, 30'h67, 32'h0, 0, "hit_after_idle");
  endtask

  task automatic abort_access(input bit rd, input bit wr, input logic [29:0] addr, input string name);
    bit seen;
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = 32'h0BAD_0BAD;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) seen = 1'b1;
      else begin
        @(posedge i_clk);
        #1;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s no_traffic: memory transfer never started", name);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL %s async_drop: rd=%b wr=%b required 0 0", name, bus.mem_read, bus.mem_write);
    end
    model_reset();
    @(posedge i_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    abort_access(1, 0, 30'h3FFF_FFFC, "abort_fill");
    do_access(1, 0, 30'h3FFF_FFFC, 32'h0, 0, "retry_fill");
    do_access(0, 1, 30'h3FFF_FFFD, 32'h7777_8888, 0, "dirty_before_abort");
    abort_access(1, 0, 30'h0000_001C, "abort_writeback");
    do_access(1, 0, 30'h0000_001C, 32'h0, 0, "retry_after_wb_abort");
    do_access(1, 0, 30'h3FFF_FFFD, 32'h0, 0, "lost_store_reads_memory");
  endtask

  task automatic test_random();
    logic [29:0] a;
    bit rd, wr;
    int k;
    for (int i = 0; i < 300; i++) begin
      a = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      k = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0) && ($urandom_range(0, 3) != 0);
      if (!rd && !wr) wr = 1'b1;
      do_access(rd, wr, a, $urandom, $urandom_range(0, 2), "random");
      if ($urandom_range(0, 7) == 0) idle_cycles($urandom_range(1, 3), 1'($urandom_range(0, 1)), "random_idle");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      do_access(0, 1, {25'd9, 3'(i), 2'd3}, 32'hB000_0000 + i, 0, "b2b_store");
    for (int i = 0; i < 8; i++)
      do_access(1, 0, {25'd10, 3'(i), 2'd3}, 32'h0, 0, "b2b_evict");
    for (int i = 0; i < 8; i++)
      do_access(1, 0, {25'd9, 3'(i), 2'd3}, 32'h0, 0, "b2b_reload");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle();
    test_reset_abort();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
